// File: rtl/pwm_capture.sv
// PWM capture: synchronises an external PWM input and measures period and high time per
// rising-edge frame, with a one-cycle valid strobe and a stuck-input flag.
module pwm_capture #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             stuck,
  output logic             level_out
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StMeas, StStuck} state_e;

  state_e                 r_state, w_state_d;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_period_cnt, w_period_cnt_d;
  logic [CNT_W-1:0]       r_high_cnt, w_high_cnt_d;
  logic [CNT_W-1:0]       r_duty, w_duty_d;
  logic [CNT_W-1:0]       r_period_out, w_period_out_d;
  logic                   r_valid, w_valid_d;
  logic                   r_stuck, w_stuck_d;

  logic w_s;
  logic w_rise;
  logic w_at_max;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_s & ~r_prev;
  assign w_at_max = (r_period_cnt == MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync       <= '0;
      r_prev       <= 1'b0;
      r_state      <= StIdle;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_duty       <= '0;
      r_period_out <= '0;
      r_valid      <= 1'b0;
      r_stuck      <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_prev       <= w_s;
      r_state      <= w_state_d;
      r_period_cnt <= w_period_cnt_d;
      r_high_cnt   <= w_high_cnt_d;
      r_duty       <= w_duty_d;
      r_period_out <= w_period_out_d;
      r_valid      <= w_valid_d;
      r_stuck      <= w_stuck_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_period_cnt_d = r_period_cnt;
    w_high_cnt_d   = r_high_cnt;
    w_duty_d       = r_duty;
    w_period_out_d = r_period_out;
    w_valid_d      = 1'b0;
    w_stuck_d      = r_stuck;

    // A rise always takes priority over the counter reaching MAX, so a frame of exactly
    // MAX cycles reports normally instead of timing out.
    case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_period_cnt_d = ONE;
          w_high_cnt_d   = ONE;
          w_state_d      = StMeas;
        end else if (w_at_max) begin
          w_valid_d      = 1'b1;
          w_period_out_d = '0;
          w_duty_d       = w_s ? MAX : '0;
          w_stuck_d      = 1'b1;
          w_state_d      = StStuck;
        end else begin
          w_period_cnt_d = r_period_cnt + ONE;
        end
      end
      StMeas: begin
        if (w_rise) begin
          w_duty_d       = r_high_cnt;
          w_period_out_d = r_period_cnt;
          w_valid_d      = 1'b1;
          w_period_cnt_d = ONE;
          w_high_cnt_d   = ONE;
        end else if (w_at_max) begin
          w_valid_d      = 1'b1;
          w_period_out_d = '0;
          w_duty_d       = w_s ? MAX : '0;
          w_stuck_d      = 1'b1;
          w_state_d      = StStuck;
        end else begin
          w_period_cnt_d = r_period_cnt + ONE;
          w_high_cnt_d   = r_high_cnt + {{(CNT_W-1){1'b0}}, w_s};
        end
      end
      StStuck: begin
        if (w_rise) begin
          w_stuck_d      = 1'b0;
          w_period_cnt_d = ONE;
          w_high_cnt_d   = ONE;
          w_state_d      = StMeas;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign duty_out   = r_duty;
  assign period_out = r_period_out;
  assign valid      = r_valid;
  assign stuck      = r_stuck;
  assign level_out  = w_s;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives known PWM frames and compares every strobe
// against hand-computed period/high-time values.
module tb_pwm_capture;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int MAX   = 255;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] duty_out;
  logic [CNT_W-1:0] period_out;
  logic             valid;
  logic             stuck;
  logic             level_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int q_per[$];
  int q_duty[$];
  int q_cyc[$];
  int q_stuck[$];

  pwm_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .duty_out  (duty_out),
    .period_out(period_out),
    .valid     (valid),
    .stuck     (stuck),
    .level_out (level_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (valid) begin
      q_per.push_back(int'(period_out));
      q_duty.push_back(int'(duty_out));
      q_cyc.push_back(cyc);
      q_stuck.push_back(int'(stuck));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic clear_q();
    q_per.delete();
    q_duty.delete();
    q_cyc.delete();
    q_stuck.delete();
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    clear_q();
  endtask

  task automatic drive_frame(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      pwm_in = (i < h);
    end
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask

  task automatic check_frames(input string tag, input int n, input int p, input int h);
    check($sformatf("%s_count", tag), q_per.size(), n);
    for (int i = 0; i < n && i < q_per.size(); i++) begin
      check($sformatf("%s_per%0d", tag, i), q_per[i], p);
      check($sformatf("%s_duty%0d", tag, i), q_duty[i], h);
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), q_cyc[i] - q_cyc[i-1], p);
    end
    check($sformatf("%s_stuck", tag), int'(stuck), 0);
  endtask

  initial begin
    int c0;
    int n0;
    int ramp[$];

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", int'({duty_out, period_out, valid, stuck, level_out}), 0);
    reset = 1'b1;
    clear_q();

    // 64-cycle frames, 20 high: six rises give five reports
    for (int f = 0; f < 6; f++) drive_frame(64, 20);
    check_frames("p64", 5, 64, 20);

    // Held low from reset: single timeout report, then recovery
    do_reset();
    c0 = cyc;
    hold(1'b0, 300);
    check("low_count", q_per.size(), 1);
    check("low_per", (q_per.size() > 0) ? q_per[0] : -1, 0);
    check("low_duty", (q_duty.size() > 0) ? q_duty[0] : -1, 0);
    check("low_stuck", (q_stuck.size() > 0) ? q_stuck[0] : -1, 1);
    check("low_latency_ok",
          (q_cyc.size() > 0) ? int'((q_cyc[0] - c0 == 255) || (q_cyc[0] - c0 == 256)) : 0, 1);
    drive_frame(64, 20);
    check("recover_stuck_clr", int'(stuck), 0);
    check("recover_no_valid", q_per.size(), 1);
    drive_frame(64, 20);
    check("recover_count", q_per.size(), 2);
    check("recover_per", (q_per.size() > 1) ? q_per[1] : -1, 64);
    check("recover_duty", (q_duty.size() > 1) ? q_duty[1] : -1, 20);

    // One rise then held high: timeout 255 cycles after the rise is consumed
    do_reset();
    hold(1'b0, 5);
    hold(1'b1, 1);
    c0 = cyc;
    hold(1'b1, 299);
    check("high_count", q_per.size(), 1);
    check("high_per", (q_per.size() > 0) ? q_per[0] : -1, 0);
    check("high_duty", (q_duty.size() > 0) ? q_duty[0] : -1, MAX);
    check("high_stuck", (q_stuck.size() > 0) ? q_stuck[0] : -1, 1);
    // SYNC edges to see the rise, one more edge to register the frame start, then 255
    check("high_latency", (q_cyc.size() > 0) ? q_cyc[0] - c0 : -1, SYNC + 1 + 255);
    check("high_level", int'(level_out), 1);

    // Short pulse frames
    do_reset();
    for (int f = 0; f < 4; f++) drive_frame(10, 1);
    check_frames("p10", 3, 10, 1);

    // Period exactly MAX: rise wins over timeout
    do_reset();
    for (int f = 0; f < 3; f++) drive_frame(255, 100);
    check_frames("p255", 2, 255, 100);

    // Asynchronous reset mid-frame
    do_reset();
    drive_frame(64, 20);
    drive_frame(64, 20);
    hold(1'b1, 10);
    @(negedge clk);
    #3;
    reset  = 1'b0;
    pwm_in = 1'b0;
    #1;
    check("async_rst_outputs", int'({duty_out, period_out, valid, stuck, level_out}), 0);
    n0 = q_per.size();
    repeat (3) @(negedge clk);
    check("async_rst_no_valid", q_per.size(), n0);
    reset = 1'b1;
    clear_q();
    for (int f = 0; f < 3; f++) drive_frame(40, 15);
    check_frames("post_rst", 2, 40, 15);

    // Breathing-style ramp of 64-cycle frames
    do_reset();
    for (int d = 8; d <= 14; d++) ramp.push_back(d);
    for (int d = 13; d >= 8; d--) ramp.push_back(d);
    foreach (ramp[i]) drive_frame(64, ramp[i]);
    drive_frame(64, 8);
    check("ramp_count", q_per.size(), ramp.size());
    for (int i = 0; i < ramp.size() && i < q_per.size(); i++) begin
      check($sformatf("ramp_per%0d", i), q_per[i], 64);
      check($sformatf("ramp_duty%0d", i), q_duty[i], ramp[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
